reg_banco_mp: RTL and testbench
===============================

// Module: reg_banco_mp
// PURPOSE
//  Parametrised multi-read-port register bank; next generation of the load/store register bank.
//  - NRD registered read ports and one write port (load write-back).
//  - Register 0 hardwired to zero.
//  - Optional write-to-read bypass.
//  - Per-register pending-load scoreboard that flags read-after-load hazards to the load/store control.
// PARAMETERS
//  W      64  data width of each register
//  NREG   32  number of registers (power of 2, >=2)
//  NRD    2   number of read ports (1..4)
//  BYPASS 1   1: a same-cycle write is forwarded to reads and masks the hazard; 0: no forwarding
//  AW     $clog2(NREG)  address width (derived, not overridden)
// PORTS
//  clk     in  1       clock, all state updates on rising edge
//  rst_n   in  1       asynchronous active-low reset
//  Ra      in  NRD*AW  read addresses; port i = Ra[i*AW +: AW]
//  doutA   out NRD*W   registered read data; port i = doutA[i*W +: W]
//  hazard  out NRD     combinational; port i reads a register with a load outstanding
//  WE_Reg  in  1       write enable
//  Rw      in  AW      write address
//  dIN     in  W       write data (from memory)
//  Iss_en  in  1       load issued; marks Iss_rd pending
//  Iss_rd  in  AW      destination register of the issued load
//  busy    out NREG    scoreboard vector, bit r = load pending on register r; bit 0 always 0
//  waw_err out 1       sticky; set when a load issues to an already-busy register
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous, any time)
//   - All registers, doutA, busy and waw_err go to 0 immediately.
//   - An in-flight write or issue in that cycle is discarded.
//  Write
//   - At posedge, if WE_Reg=1 and Rw!=0: reg[Rw] <= dIN.
//   - A write with Rw=0 is ignored; reg[0] reads 0 forever.
//  Read (1-cycle latency)
//   - At posedge, doutA[i] <= value selected by Ra[i] in that cycle:
//     - Ra[i]==0 -> 0.
//     - Else if BYPASS=1, WE_Reg=1 and Rw==Ra[i] -> dIN (new value).
//     - Else reg[Ra[i]] (old value when BYPASS=0).
//   - Ports are independent; any number of ports may address the same register.
//  Scoreboard
//   - At posedge: Iss_en=1 and Iss_rd!=0 sets busy[Iss_rd].
//   - At posedge: WE_Reg=1 and Rw!=0 clears busy[Rw].
//   - Issue and write to the same register in the same cycle: set wins; busy stays 1, the new load is outstanding.
//   - Issue with Iss_rd=0 has no effect.
//   - Iss_en=1 to a register already busy and not cleared that cycle sets waw_err; only reset clears it.
//  Hazard
//   - hazard[i] = busy[Ra[i]], AND NOT (BYPASS && WE_Reg && Rw==Ra[i]).
//   - Purely combinational from current busy and inputs.
//   - Ra[i]==0 never hazards.
//  Widths
//   - No arithmetic. Out-of-range addresses cannot occur (NREG = 2**AW).
// TESTING
//  T1 reset: drive rst_n=0 mid-write of 0xDEAD to r5 -> doutA=0, busy=0; r5 reads 0 after release.
//  T2 write/read:
//   - write r3=0x1122334455667788, then Ra0=3 -> doutA0=0x1122334455667788 one cycle later.
//   - write r0=0xFF -> reads 0.
//  T3 bypass: same cycle WE_Reg=1, Rw=7, dIN=0xABCD, Ra1=7, r7 old=0x1
//   - BYPASS=1 -> doutA1=0xABCD.
//   - BYPASS=0 -> doutA1=0x1, then 0xABCD the next cycle.
//  T4 scoreboard: issue rd=9, then Ra0=9
//   - hazard0=1 until write-back of r9.
//   - In the write-back cycle hazard0=0 (BYPASS=1) or 1 (BYPASS=0).
//   - busy[9]=0 after.
//  T5 collision:
//   - Issue rd=4 and write Rw=4 same cycle -> busy[4]=1.
//   - Second issue to r4 without write-back -> waw_err=1 and it stays 1.
//  T6 multiport: NRD=4, all ports Ra=12 with r12=0x55 -> all four doutA=0x55, hazard=0000.

Source files
------------

// File: rtl/reg_banco_mp_if.sv
// Bus bundle for reg_banco_mp: read ports, load write-back, load issue and scoreboard status.
// The master side (load/store control) drives addresses and write-back; the slave side is the bank.
interface reg_banco_mp_if #(
    parameter int W    = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2
) ();
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0] Ra;
    logic [NRD*W-1:0]  doutA;
    logic [NRD-1:0]    hazard;
    logic              WE_Reg;
    logic [AW-1:0]     Rw;
    logic [W-1:0]      dIN;
    logic              Iss_en;
    logic [AW-1:0]     Iss_rd;
    logic [NREG-1:0]   busy;
    logic              waw_err;

    modport master (
        output Ra, WE_Reg, Rw, dIN, Iss_en, Iss_rd,
        input  doutA, hazard, busy, waw_err
    );

    modport slave (
        input  Ra, WE_Reg, Rw, dIN, Iss_en, Iss_rd,
        output doutA, hazard, busy, waw_err
    );
endinterface

// File: rtl/reg_banco_mp.sv
// Multi-read-port register bank with r0 hardwired to zero, optional write-to-read bypass
// and a per-register pending-load scoreboard that flags read-after-load hazards.
module reg_banco_mp #(
    parameter int W      = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input logic             clk,
    input logic             rst_n,
    reg_banco_mp_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    logic [W-1:0]     r_regs [NREG];
    logic [NRD*W-1:0] r_dout;
    logic [NREG-1:0]  r_busy;
    logic             r_waw;

    logic [NREG-1:0]  w_busy_nxt;
    logic             w_wr;
    logic             w_iss;
    logic             w_waw;
    logic [AW-1:0]    w_ra    [NRD];
    logic [W-1:0]     w_rdata [NRD];
    logic             w_fwd   [NRD];
    logic [NRD-1:0]   w_hazard;

    always_comb begin
        w_wr  = bus.WE_Reg && (bus.Rw != '0);
        w_iss = bus.Iss_en && (bus.Iss_rd != '0);

        for (int unsigned i = 0; i < NRD; i++) begin
            w_ra[i]  = bus.Ra[i*AW +: AW];
            w_fwd[i] = (BYPASS != 0) && bus.WE_Reg && (bus.Rw == w_ra[i]);
            if (w_ra[i] == '0)
                w_rdata[i] = '0;
            else if (w_fwd[i])
                w_rdata[i] = bus.dIN;
            else
                w_rdata[i] = r_regs[w_ra[i]];
            // busy[0] is never set, so reads of r0 can never hazard
            w_hazard[i] = r_busy[w_ra[i]] && !w_fwd[i];
        end

        // Clear on write-back first, then set on issue, so a same-cycle issue wins
        w_busy_nxt = r_busy;
        if (w_wr)
            w_busy_nxt[bus.Rw] = 1'b0;
        if (w_iss)
            w_busy_nxt[bus.Iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;

        w_waw = w_iss && r_busy[bus.Iss_rd] && !(w_wr && (bus.Rw == bus.Iss_rd));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_dout <= '0;
            r_busy <= '0;
            r_waw  <= 1'b0;
        end else begin
            if (w_wr)
                r_regs[bus.Rw] <= bus.dIN;
            for (int unsigned i = 0; i < NRD; i++)
                r_dout[i*W +: W] <= w_rdata[i];
            r_busy <= w_busy_nxt;
            if (w_waw)
                r_waw <= 1'b1;
        end
    end

    assign bus.doutA   = r_dout;
    assign bus.hazard  = w_hazard;
    assign bus.busy    = r_busy;
    assign bus.waw_err = r_waw;
endmodule

// File: tb/tb_reg_banco_mp.sv
// Directed bench for reg_banco_mp: a 4-port bypassing bank and a 2-port non-bypassing bank
// driven by the same stimulus, each checked against hand-computed values.
module tb_reg_banco_mp;
    localparam int W    = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    reg_banco_mp_if #(.W(W), .NREG(NREG), .NRD(4)) if_a ();
    reg_banco_mp_if #(.W(W), .NREG(NREG), .NRD(2)) if_b ();

    reg_banco_mp #(.W(W), .NREG(NREG), .NRD(4), .BYPASS(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    reg_banco_mp #(.W(W), .NREG(NREG), .NRD(2), .BYPASS(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    assign if_b.Ra     = if_a.Ra[2*AW-1:0];
    assign if_b.WE_Reg = if_a.WE_Reg;
    assign if_b.Rw     = if_a.Rw;
    assign if_b.dIN    = if_a.dIN;
    assign if_b.Iss_en = if_a.Iss_en;
    assign if_b.Iss_rd = if_a.Iss_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        if_a.Ra = {a3, a2, a1, a0};
    endtask

    task automatic idle();
        if_a.WE_Reg = 1'b0;
        if_a.Rw     = '0;
        if_a.dIN    = '0;
        if_a.Iss_en = 1'b0;
        if_a.Iss_rd = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();
        set_ra(0, 0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // T1: reset asserted mid-cycle while a write and issue to r5 are pending
        if_a.WE_Reg = 1'b1; if_a.Rw = 5; if_a.dIN = 64'hDEAD;
        if_a.Iss_en = 1'b1; if_a.Iss_rd = 5;
        set_ra(5, 5, 5, 5);
        #3 rst_n = 1'b0;
        tick();
        chk("t1_rst_dout_a", if_a.doutA[63:0], 64'h0);
        chk("t1_rst_busy_a", {32'h0, if_a.busy}, 64'h0);
        chk("t1_rst_waw_a", {63'h0, if_a.waw_err}, 64'h0);
        idle();
        #2 rst_n = 1'b1;
        tick();
        tick();
        chk("t1_r5_a", if_a.doutA[63:0], 64'h0);
        chk("t1_r5_b", if_b.doutA[63:0], 64'h0);
        chk("t1_busy_a", {32'h0, if_a.busy}, 64'h0);

        // T2: plain write then read; write to r0 is dropped
        if_a.WE_Reg = 1'b1; if_a.Rw = 3; if_a.dIN = 64'h1122334455667788;
        set_ra(0, 0, 0, 0);
        tick();
        idle();
        set_ra(3, 0, 0, 0);
        tick();
        chk("t2_r3_a", if_a.doutA[63:0], 64'h1122334455667788);
        chk("t2_r3_b", if_b.doutA[63:0], 64'h1122334455667788);
        if_a.WE_Reg = 1'b1; if_a.Rw = 0; if_a.dIN = 64'hFF;
        set_ra(3, 0, 0, 0);
        tick();
        idle();
        set_ra(0, 0, 0, 0);
        tick();
        chk("t2_r0_a", if_a.doutA[63:0], 64'h0);
        chk("t2_r0_b", if_b.doutA[63:0], 64'h0);
        chk("t2_busy_a", {32'h0, if_a.busy}, 64'h0);

        // T3: write-to-read bypass on port 1
        if_a.WE_Reg = 1'b1; if_a.Rw = 7; if_a.dIN = 64'h1;
        tick();
        if_a.dIN = 64'hABCD;
        set_ra(0, 7, 0, 0);
        tick();
        chk("t3_byp_a", if_a.doutA[127:64], 64'hABCD);
        chk("t3_nobyp_b", if_b.doutA[127:64], 64'h1);
        idle();
        tick();
        chk("t3_after_a", if_a.doutA[127:64], 64'hABCD);
        chk("t3_after_b", if_b.doutA[127:64], 64'hABCD);

        // T4: load to r9 outstanding until write-back
        if_a.Iss_en = 1'b1; if_a.Iss_rd = 9;
        set_ra(0, 0, 0, 0);
        tick();
        idle();
        set_ra(9, 0, 0, 0);
        #1;
        chk("t4_busy_a", {32'h0, if_a.busy}, 64'h200);
        chk("t4_haz_a", {60'h0, if_a.hazard}, 64'h1);
        chk("t4_haz_b", {62'h0, if_b.hazard}, 64'h1);
        tick();
        chk("t4_haz_hold_a", {60'h0, if_a.hazard}, 64'h1);
        if_a.WE_Reg = 1'b1; if_a.Rw = 9; if_a.dIN = 64'h99;
        #1;
        chk("t4_wb_haz_a", {60'h0, if_a.hazard}, 64'h0);
        chk("t4_wb_haz_b", {62'h0, if_b.hazard}, 64'h1);
        tick();
        idle();
        #1;
        chk("t4_wb_dout_a", if_a.doutA[63:0], 64'h99);
        chk("t4_wb_dout_b", if_b.doutA[63:0], 64'h0);
        chk("t4_busy_clr_a", {32'h0, if_a.busy}, 64'h0);
        chk("t4_haz_clr_a", {60'h0, if_a.hazard}, 64'h0);
        chk("t4_haz_clr_b", {62'h0, if_b.hazard}, 64'h0);

        // Issue to r0 is ignored
        if_a.Iss_en = 1'b1; if_a.Iss_rd = 0;
        set_ra(0, 0, 0, 0);
        tick();
        idle();
        chk("t4_iss_r0_busy", {32'h0, if_a.busy}, 64'h0);

        // T5: issue and write-back to r4 in the same cycle, then a second issue
        if_a.Iss_en = 1'b1; if_a.Iss_rd = 4;
        if_a.WE_Reg = 1'b1; if_a.Rw = 4; if_a.dIN = 64'h44;
        tick();
        idle();
        chk("t5_busy_a", {32'h0, if_a.busy}, 64'h10);
        chk("t5_waw0_a", {63'h0, if_a.waw_err}, 64'h0);
        if_a.Iss_en = 1'b1; if_a.Iss_rd = 4;
        tick();
        idle();
        chk("t5_waw1_a", {63'h0, if_a.waw_err}, 64'h1);
        chk("t5_waw1_b", {63'h0, if_b.waw_err}, 64'h1);
        if_a.WE_Reg = 1'b1; if_a.Rw = 4; if_a.dIN = 64'h45;
        tick();
        idle();
        tick();
        chk("t5_waw_sticky_a", {63'h0, if_a.waw_err}, 64'h1);
        chk("t5_busy_clr_a", {32'h0, if_a.busy}, 64'h0);

        // T6: all four ports read the same register
        if_a.WE_Reg = 1'b1; if_a.Rw = 12; if_a.dIN = 64'h55;
        tick();
        idle();
        set_ra(12, 12, 12, 12);
        tick();
        chk("t6_p0_a", if_a.doutA[63:0], 64'h55);
        chk("t6_p1_a", if_a.doutA[127:64], 64'h55);
        chk("t6_p2_a", if_a.doutA[191:128], 64'h55);
        chk("t6_p3_a", if_a.doutA[255:192], 64'h55);
        chk("t6_haz_a", {60'h0, if_a.hazard}, 64'h0);
        chk("t6_p1_b", if_b.doutA[127:64], 64'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
